// File: rtl/uart_tx.sv
// UART transmit serializer: start bit, LSB-first data, optional parity, stop bit(s).
// Bit timing comes from an external baud counter enabled through baud_en.
module uart_tx #(
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  input  logic                 baud_tick,
  output logic                 baud_en,
  output logic                 tx,
  output logic                 busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  localparam int CNT_W = 4;
  localparam logic [CNT_W-1:0] LAST_DATA = CNT_W'(DATA_BITS - 1);
  localparam logic [CNT_W-1:0] LAST_STOP = CNT_W'(STOP_BITS - 1);

  state_t               r_state,  w_state_nxt;
  logic [DATA_BITS-1:0] r_shift,  w_shift_nxt;
  logic [CNT_W-1:0]     r_cnt,    w_cnt_nxt;
  logic                 r_parity, w_parity_nxt;
  logic                 r_tx,     w_tx_nxt;
  logic                 r_ready,  w_ready_nxt;
  logic                 r_busy;
  logic                 r_baud_en;

  // Next-state logic; outputs below are decoded from the next state so that
  // the registered line value changes on the same edge as the transition.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    w_state_nxt  = r_state;
    w_shift_nxt  = r_shift;
    w_cnt_nxt    = r_cnt;
    w_parity_nxt = r_parity;

    unique case (r_state)
      S_IDLE: begin
        if (tx_valid && r_ready) begin
          w_state_nxt  = S_START;
          w_shift_nxt  = tx_data;
          w_cnt_nxt    = '0;
          w_parity_nxt = (PARITY == 1) ? ~^tx_data : ^tx_data;
        end
      end
      S_START: begin
        if (baud_tick) begin
          w_state_nxt = S_DATA;
          w_cnt_nxt   = '0;
        end
      end
      S_DATA: begin
        if (baud_tick) begin
          w_shift_nxt = r_shift >> 1;
          if (r_cnt == LAST_DATA) begin
            w_cnt_nxt   = '0;
            w_state_nxt = (PARITY != 0) ? S_PARITY : S_STOP;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
      end
      S_PARITY: begin
        if (baud_tick) begin
          w_state_nxt = S_STOP;
          w_cnt_nxt   = '0;
        end
      end
      S_STOP: begin
        if (baud_tick) begin
          if (r_cnt == LAST_STOP) begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

    w_tx_nxt = 1'b1;
    unique case (w_state_nxt)
      S_START:  w_tx_nxt = 1'b0;
      S_DATA:   w_tx_nxt = w_shift_nxt[0];
      S_PARITY: w_tx_nxt = w_parity_nxt;
      default:  w_tx_nxt = 1'b1;
    endcase

    w_ready_nxt = (w_state_nxt == S_IDLE);
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (rst) begin
      r_state   <= S_IDLE;
      r_shift   <= '0;
      r_cnt     <= '0;
      r_parity  <= 1'b0;
      r_tx      <= 1'b1;
      r_ready   <= 1'b1;
      r_busy    <= 1'b0;
      r_baud_en <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_shift   <= w_shift_nxt;
      r_cnt     <= w_cnt_nxt;
      r_parity  <= w_parity_nxt;
      r_tx      <= w_tx_nxt;
      r_ready   <= w_ready_nxt;
      r_busy    <= ~w_ready_nxt;
      r_baud_en <= ~w_ready_nxt;
    end
  end

  assign tx       = r_tx;
  assign tx_ready = r_ready;
  assign busy     = r_busy;
  assign baud_en  = r_baud_en;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: three configurations (8N1, 8E2, 8O1) driven by
// a modelled baud counter; expected line bits are queued at accept and checked per tick.
module tb_uart_tx;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic [2:0][7:0] tx_data;
  logic [2:0]      tx_valid;
  logic [2:0]      mtick      = 3'b000;
  logic [2:0]      force_tick = 3'b000;
  logic [2:0]      w_tick;
  wire  [2:0]      tx_ready;
  wire  [2:0]      baud_en;
  wire  [2:0]      tx;
  wire  [2:0]      busy;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  int bp[3]        = '{16, 4, 4};
  int par[3]       = '{0, 2, 1};
  int nstop[3]     = '{1, 2, 1};
  int bcnt[3]      = '{0, 0, 0};
  int tick_cnt[3]  = '{0, 0, 0};
  int en_cycles[3] = '{0, 0, 0};

  int last_ready_cyc;
  int last_acc_cyc;
  int last_wait;

  logic q0[$];
  logic q1[$];
  logic q2[$];

  assign w_tick = mtick | force_tick;

  uart_tx #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_dut0 (
    .clk(clk), .rst(rst), .tx_data(tx_data[0]), .tx_valid(tx_valid[0]),
    .tx_ready(tx_ready[0]), .baud_tick(w_tick[0]), .baud_en(baud_en[0]),
    .tx(tx[0]), .busy(busy[0])
  );

  uart_tx #(.DATA_BITS(8), .PARITY(2), .STOP_BITS(2)) u_dut1 (
    .clk(clk), .rst(rst), .tx_data(tx_data[1]), .tx_valid(tx_valid[1]),
    .tx_ready(tx_ready[1]), .baud_tick(w_tick[1]), .baud_en(baud_en[1]),
    .tx(tx[1]), .busy(busy[1])
  );

  uart_tx #(.DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u_dut2 (
    .clk(clk), .rst(rst), .tx_data(tx_data[2]), .tx_valid(tx_valid[2]),
    .tx_ready(tx_ready[2]), .baud_tick(w_tick[2]), .baud_en(baud_en[2]),
    .tx(tx[2]), .busy(busy[2])
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_bit(input int k, input logic b);
    case (k)
      0:       q0.push_back(b);
      1:       q1.push_back(b);
      default: q2.push_back(b);
    endcase
  endtask

  // Reference frame: start, LSB-first data, parity (odd = ~^d, even = ^d), stop bits.
  task automatic push_frame(input int k, input logic [7:0] d);
    push_bit(k, 1'b0);
    for (int i = 0; i < 8; i++) push_bit(k, d[i]);
    if (par[k] == 1) push_bit(k, ~^d);
    else if (par[k] == 2) push_bit(k, ^d);
    for (int i = 0; i < nstop[k]; i++) push_bit(k, 1'b1);
  endtask

  task automatic pop_check(input int k);
    int   n;
    logic e;
    n = (k == 0) ? q0.size() : (k == 1) ? q1.size() : q2.size();
    check($sformatf("dut%0d_bit_expected", k), 32'(n != 0), 32'd1);
    if (n != 0) begin
      case (k)
        0:       e = q0.pop_front();
        1:       e = q1.pop_front();
        default: e = q2.pop_front();
      endcase
      check($sformatf("dut%0d_tx_bit%0d", k, tick_cnt[k]), 32'(tx[k]), 32'(e));
    end
  endtask

  // Baud counter model: restarts while baud_en is low, pulses every bp[k] cycles.
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (!baud_en[k]) begin
        bcnt[k]  = 0;
        mtick[k] = 1'b0;
      end else begin
        en_cycles[k]++;
        bcnt[k]++;
        mtick[k] = (bcnt[k] == bp[k]);
        if (mtick[k]) bcnt[k] = 0;
      end
      if (mtick[k]) begin
        tick_cnt[k]++;
        pop_check(k);
      end
    end
  end

  task automatic send(input int k, input logic [7:0] d, input bit keep_valid, input bit tick_on_accept);
    int t;
    @(negedge clk);
    tx_data[k]  = d;
    tx_valid[k] = 1'b1;
    t = 0;
    while (!tx_ready[k] && t < 5000) begin
      @(negedge clk);
      t++;
    end
    check($sformatf("dut%0d_ready_timeout", k), 32'(t < 5000), 32'd1);
    last_wait      = t;
    last_ready_cyc = cyc;
    if (tick_on_accept) force_tick[k] = 1'b1;
    @(posedge clk);
    push_frame(k, d);
    #1;
    last_acc_cyc  = cyc;
    force_tick[k] = 1'b0;
    check($sformatf("dut%0d_accept_tx", k),       32'(tx[k]),       32'd0);
    check($sformatf("dut%0d_accept_ready", k),    32'(tx_ready[k]), 32'd0);
    check($sformatf("dut%0d_accept_busy", k),     32'(busy[k]),     32'd1);
    check($sformatf("dut%0d_accept_baud_en", k),  32'(baud_en[k]),  32'd1);
    @(negedge clk);
    tx_data[k] = ~d;
    if (!keep_valid) tx_valid[k] = 1'b0;
  endtask

  task automatic wait_idle(input int k);
    int t;
    t = 0;
    @(negedge clk);
    while (!tx_ready[k] && t < 5000) begin
      @(negedge clk);
      t++;
    end
    check($sformatf("dut%0d_idle_timeout", k), 32'(t < 5000), 32'd1);
  endtask

  task automatic check_idle(input string tag);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("%s_tx%0d", tag, k),      32'(tx[k]),       32'd1);
      check($sformatf("%s_ready%0d", tag, k),   32'(tx_ready[k]), 32'd1);
      check($sformatf("%s_busy%0d", tag, k),    32'(busy[k]),     32'd0);
      check($sformatf("%s_baud_en%0d", tag, k), 32'(baud_en[k]),  32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int a1;
    int base;
    int t;
    tx_valid = 3'b111;
    tx_data  = {8'hA5, 8'hA5, 8'hA5};

    // Reset held two cycles with tx_valid high: no frame may start.
    @(posedge clk); #1;
    check_idle("rst_cyc1");
    @(posedge clk); #1;
    check_idle("rst_cyc2");
    @(negedge clk);
    tx_valid = 3'b000;
    rst      = 1'b0;
    @(posedge clk); #1;
    check_idle("post_rst");

    // 8N1 0xA5: ten line bits, baud_en high 160 cycles, tx_ready back on cycle 161.
    en_cycles[0] = 0;
    send(0, 8'hA5, 1'b0, 1'b0);
    a1 = last_acc_cyc;
    wait_idle(0);
    check("a5_ready_cycle",  32'(cyc - a1),      32'd160);
    check("a5_baud_en_cyc",  32'(en_cycles[0]),  32'd160);
    check("a5_queue_empty",  32'(q0.size()),     32'd0);

    // Even parity / 2 stop and odd parity / 1 stop, both with 0x07, then other patterns.
    send(1, 8'h07, 1'b0, 1'b0);
    send(2, 8'h07, 1'b0, 1'b0);
    wait_idle(1);
    wait_idle(2);
    send(1, 8'hE1, 1'b0, 1'b0);
    send(2, 8'h00, 1'b0, 1'b0);
    wait_idle(1);
    wait_idle(2);
    check("par_q1_empty", 32'(q1.size()), 32'd0);
    check("par_q2_empty", 32'(q2.size()), 32'd0);

    // Back-to-back with tx_valid held: 0x55 then 0xFF, one idle cycle between frames.
    send(0, 8'h55, 1'b1, 1'b0);
    a1 = last_acc_cyc;
    send(0, 8'hFF, 1'b0, 1'b0);
    check("b2b_waited",       32'(last_wait > 0),              32'd1);
    check("b2b_gap",          32'(last_acc_cyc - last_ready_cyc), 32'd1);
    check("b2b_frame_period", 32'(last_acc_cyc - a1),          32'd161);
    wait_idle(0);

    // Handshake while busy: data change and valid pulse mid-frame are ignored.
    send(0, 8'h96, 1'b0, 1'b0);
    repeat (40) @(posedge clk);
    @(negedge clk);
    tx_data[0]  = 8'h00;
    tx_valid[0] = 1'b1;
    @(negedge clk);
    tx_valid[0] = 1'b0;
    check("busy_pulse_ready", 32'(tx_ready[0]), 32'd0);
    check("busy_pulse_busy",  32'(busy[0]),     32'd1);
    repeat (20) @(posedge clk);
    send(0, 8'h0F, 1'b0, 1'b0);
    check("busy_pending_waited", 32'(last_wait > 0), 32'd1);
    wait_idle(0);
    check("busy_queue_empty", 32'(q0.size()), 32'd0);

    // Reset during data bit 3 with a coincident baud tick: reset wins, frame abandoned.
    send(0, 8'hC3, 1'b0, 1'b0);
    base = tick_cnt[0];
    t = 0;
    while (tick_cnt[0] - base < 4 && t < 2000) begin
      @(posedge clk);
      t++;
    end
    check("rst_mid_reach_bit3", 32'(t < 2000), 32'd1);
    #1;
    rst           = 1'b1;
    force_tick[0] = 1'b1;
    @(posedge clk); #1;
    check_idle("rst_mid");
    rst           = 1'b0;
    force_tick[0] = 1'b0;
    q0.delete();

    // Fresh 0x3C frame after the abort, with a baud tick on the accept cycle.
    send(0, 8'h3C, 1'b0, 1'b1);
    @(posedge clk); #1;
    check("accept_tick_still_start", 32'(tx[0]), 32'd0);
    wait_idle(0);
    check("final_q0_empty", 32'(q0.size()), 32'd0);
    check_idle("end");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
# uart_tx

UART transmit serializer sitting directly downstream of the baud-rate counter in the UART peripheral. Accepts one data word per frame over a valid/ready handshake and drives the `en` input of the baud counter through `baud_en`. Consumes the counter's one-cycle `out` pulse as `baud_tick` and shifts a standard async frame onto the serial line: start bit, data LSB first, optional parity, stop bit(s).

## Interface
- `DATA_BITS`, 8: data word width; legal 5–9.
- `PARITY`, 0: 0 = none, 1 = odd, 2 = even.
- `STOP_BITS`, 1: stop bits per frame; legal 1 or 2.
- `clk`  in  1: system clock; all logic is on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `tx_data`  in  DATA_BITS: word to send; sampled only on the accept cycle.
- `tx_valid`  in  1: upstream has a word.
- `tx_ready`  out  1: block can accept a word; high only in IDLE.
- `baud_tick`  in  1: one-cycle pulse per bit period, from the baud counter `out`.
- `baud_en`  out  1: enable for the baud counter; high for the whole frame.
- `tx`  out  1: serial line; idle high.
- `busy`  out  1: frame in progress; equals `~tx_ready`.

## Operation
- All outputs are registered. Reset values: `tx` = 1, `tx_ready` = 1, `busy` = 0, `baud_en` = 0. State = IDLE; the shift register and bit counter clear to 0.
- Accept: `tx_valid & tx_ready` on a rising edge.
  - Latches `tx_data` into the shift register.
  - Computes the parity bit: odd = `~^data`, even = `^data`.
  - Moves to START.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: `tx` = 1, `baud_en` = 0. `baud_tick` is ignored.
  - START: `tx` = 0. On `baud_tick`, go to DATA with bit counter = 0.
  - DATA: `tx` = shift[0]. On `baud_tick`, shift right and increment the counter. After DATA_BITS ticks, go to PARITY if PARITY≠0, else STOP.
  - PARITY: `tx` = parity bit. On `baud_tick`, go to STOP.
  - STOP: `tx` = 1. After STOP_BITS ticks, go to IDLE.
- `baud_en` is 1 in every state except IDLE. The counter therefore restarts from zero on each frame, and each bit lasts exactly one full tick period.
- `tx_data` changes after the accept cycle have no effect on the frame in flight.
- `tx_valid` while busy: ignored. The word is held upstream until `tx_ready` returns.
- Back-to-back frames: `tx_ready` rises the cycle after the last stop tick. If `tx_valid` is high on that cycle, the next START begins on the following edge. The minimum idle time between frames is 1 clock cycle.
- Reset during a frame: on the next edge the FSM returns to IDLE, `tx` = 1 and `baud_en` = 0. The partial frame is abandoned with no resume.
- A `baud_tick` on the same cycle as `rst`: reset wins.
- A `baud_tick` on the accept cycle: ignored, because the FSM is still in IDLE.

## Timing
- Accept edge E0: on the same edge `tx` goes to 0, `tx_ready` to 0, `busy` to 1 and `baud_en` to 1.
- Each state transition happens on the edge where `baud_tick` = 1. The new `tx` value is visible on that same edge.
- With a baud period of N cycles, frame length = (1 + DATA_BITS + (PARITY≠0) + STOP_BITS) × N cycles from E0. `tx_ready` = 1 one edge after the final tick.
- Latency from accept to the first start-bit edge is 0 cycles after E0.

## Test plan
- Reset: hold `rst` for 2 cycles with `tx_valid` = 1 → `tx` = 1, `tx_ready` = 1, `baud_en` = 0, and no frame starts while `rst` = 1.
- 8N1, `tx_data` = 0xA5, tick every 16 cycles → `tx` reads 0,1,0,1,0,0,1,0,1,1 at successive ticks. `baud_en` is high for exactly 160 cycles. `tx_ready` is 1 on cycle 161.
- PARITY = 2 (even), STOP_BITS = 2, `tx_data` = 0x07 → bits 0, 1,1,1,0,0,0,0,0, parity 1, 1, 1. With PARITY = 1 the parity bit is 0.
- Back-to-back: `tx_valid` held high with 0x55 then 0xFF → the second start bit begins exactly 1 cycle after `tx_ready` rises. No extra stop time is inserted.
- Handshake under busy: change `tx_data` and pulse `tx_valid` mid-frame → the frame in flight is unchanged and the pending word is accepted only when `tx_ready` = 1.
- Reset mid-frame: assert `rst` during data bit 3 → on the next edge `tx` = 1, `baud_en` = 0, `tx_ready` = 1. A new 0x3C frame then transmits correctly.
